// File: rtl/hour_timer_log.sv
// hour_timer_log
//   Work-day timebase and per-hour log storage for the parking system.
//   A cycle counter divides clk into one-second ticks. A second counter
//   divides those into work-hour ticks. The block tracks the current work
//   hour and flags the end of the work day. An 8x16 simple dual-port RAM
//   holds one log word per hour.
//
// Ports
//   clk                 system clock, rising edge
//   reset               asynchronous active-low reset
//   work_day_increment  synchronous start-new-day request (level sampled)
//   work_hour           current work hour, 0..NUM_HOURS-1
//   expired_one_second  one-cycle pulse per elapsed second
//   expired_one_hour    one-cycle pulse per elapsed work hour
//   work_day_expired    level, set once all NUM_HOURS hours have elapsed
//   wr_addr/wr_data/wr_en  RAM write port (synchronous)
//   rd_addr/rd_data        RAM read port (synchronous, 1-cycle latency)
module hour_timer_log #(
  parameter int CNT_1S    = 50_000_000,
  parameter int CNT_HOUR  = 3600,
  parameter int NUM_HOURS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        work_day_increment,
  output logic [3:0]  work_hour,
  output logic        expired_one_second,
  output logic        expired_one_hour,
  output logic        work_day_expired,
  input  logic [2:0]  wr_addr,
  input  logic [15:0] wr_data,
  input  logic        wr_en,
  input  logic [2:0]  rd_addr,
  output logic [15:0] rd_data
);

  localparam int CYC_W = (CNT_1S > 1) ? $clog2(CNT_1S) : 1;
  localparam int SEC_W = (CNT_HOUR > 1) ? $clog2(CNT_HOUR) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CNT_1S - 1);
  localparam logic [CYC_W-1:0] CYC_ZERO  = CYC_W'(0);
  localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);
  localparam logic [SEC_W-1:0] SEC_LAST  = SEC_W'(CNT_HOUR - 1);
  localparam logic [SEC_W-1:0] SEC_ZERO  = SEC_W'(0);
  localparam logic [SEC_W-1:0] SEC_ONE   = SEC_W'(1);
  localparam logic [3:0]       HOUR_LAST = 4'(NUM_HOURS - 1);

  logic [CYC_W-1:0] cyc_cnt_r;
  logic [SEC_W-1:0] sec_cnt_r;
  logic [3:0]       work_hour_r;
  logic             sec_tick_r;
  logic             hour_tick_r;
  logic             day_done_r;
  logic [15:0]      rd_data_r;
  logic [15:0]      mem_r [0:7];

  logic [CYC_W-1:0] cyc_next_s;
  logic [SEC_W-1:0] sec_next_s;
  logic [3:0]       hour_next_s;
  logic             day_next_s;
  logic             sec_wrap_s;
  logic             hour_wrap_s;
  logic             sec_tick_next_s;
  logic             hour_tick_next_s;

  // Next-state logic for the cycle/second/hour counters and the tick pulses.
  always_comb begin
    sec_wrap_s       = (cyc_cnt_r == CYC_LAST);
    // No hour ticks once the day is over; the second counter stays frozen then.
    hour_wrap_s      = sec_wrap_s && !day_done_r && (sec_cnt_r == SEC_LAST);
    cyc_next_s       = cyc_cnt_r;
    sec_next_s       = sec_cnt_r;
    hour_next_s      = work_hour_r;
    day_next_s       = day_done_r;
    sec_tick_next_s  = 1'b0;
    hour_tick_next_s = 1'b0;

    if (work_day_increment) begin
      // A new-day request wins over any tick or expiry on the same edge.
      cyc_next_s       = CYC_ZERO;
      sec_next_s       = SEC_ZERO;
      hour_next_s      = 4'd0;
      day_next_s       = 1'b0;
      sec_tick_next_s  = 1'b0;
      hour_tick_next_s = 1'b0;
    end else begin
      sec_tick_next_s  = sec_wrap_s;
      hour_tick_next_s = hour_wrap_s;

      if (sec_wrap_s) begin
        cyc_next_s = CYC_ZERO;
      end else begin
        cyc_next_s = cyc_cnt_r + CYC_ONE;
      end

      if (day_done_r) begin
        sec_next_s = SEC_ZERO;
      end else if (sec_wrap_s) begin
        if (sec_cnt_r == SEC_LAST) begin
          sec_next_s = SEC_ZERO;
        end else begin
          sec_next_s = sec_cnt_r + SEC_ONE;
        end
      end else begin
        sec_next_s = sec_cnt_r;
      end

      // work_hour advances the edge after the hour pulse, so consumers
      // sampling on the pulse still see the hour that just completed.
      if (hour_tick_r) begin
        if (work_hour_r == HOUR_LAST) begin
          hour_next_s = work_hour_r;
          day_next_s  = 1'b1;
        end else begin
          hour_next_s = work_hour_r + 4'd1;
          day_next_s  = day_done_r;
        end
      end else begin
        hour_next_s = work_hour_r;
        day_next_s  = day_done_r;
      end
    end
  end

  // Timebase state registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cyc_cnt_r   <= CYC_ZERO;
      sec_cnt_r   <= SEC_ZERO;
      work_hour_r <= 4'd0;
      sec_tick_r  <= 1'b0;
      hour_tick_r <= 1'b0;
      day_done_r  <= 1'b0;
    end else begin
      cyc_cnt_r   <= cyc_next_s;
      sec_cnt_r   <= sec_next_s;
      work_hour_r <= hour_next_s;
      sec_tick_r  <= sec_tick_next_s;
      hour_tick_r <= hour_tick_next_s;
      day_done_r  <= day_next_s;
    end
  end

  // Hour-log RAM write port; contents survive a new-day request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 8; i++) begin
        mem_r[i] <= 16'h0000;
      end
    end else if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Hour-log RAM read port; a same-address write returns the old word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data_r <= 16'h0000;
    end else begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign work_hour          = work_hour_r;
  assign expired_one_second = sec_tick_r;
  assign expired_one_hour   = hour_tick_r;
  assign work_day_expired   = day_done_r;
  assign rd_data            = rd_data_r;

endmodule

// File: tb/tb_hour_timer_log.sv
// Testbench for hour_timer_log with small timebase parameters.
// A behavioural model derives every expected output from the number of
// edges since the last restart and from an array copy of the RAM.
module tb_hour_timer_log;

  localparam int C1 = 5;
  localparam int CH = 5;
  localparam int NH = 8;
  localparam int HP = C1 * CH;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        work_day_increment = 1'b0;
  logic [3:0]  work_hour;
  logic        expired_one_second;
  logic        expired_one_hour;
  logic        work_day_expired;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_data = 16'h0000;
  logic        wr_en = 1'b0;
  logic [2:0]  rd_addr = 3'd0;
  logic [15:0] rd_data;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  hour_timer_log #(.CNT_1S(C1), .CNT_HOUR(CH), .NUM_HOURS(NH)) dut (
    .clk(clk),
    .reset(reset),
    .work_day_increment(work_day_increment),
    .work_hour(work_hour),
    .expired_one_second(expired_one_second),
    .expired_one_hour(expired_one_hour),
    .work_day_expired(work_day_expired),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  // Model state: edges since reset/new-day, RAM image, expected read data.
  int          n_m = 0;
  logic [15:0] mem_m [8];
  logic [15:0] rd_m = 16'h0000;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_m  <= 0;
      rd_m <= 16'h0000;
      for (int i = 0; i < 8; i++) mem_m[i] <= 16'h0000;
    end else begin
      rd_m <= mem_m[rd_addr];
      if (wr_en) mem_m[wr_addr] <= wr_data;
      n_m <= work_day_increment ? 0 : n_m + 1;
    end
  end

  // Hours completed before the current cycle, capped at NH.
  function automatic int hours_done(input int n);
    int k;
    if (n == 0) return 0;
    k = (n - 1) / HP;
    return (k > NH) ? NH : k;
  endfunction

  function automatic logic exp_sec(input int n);
    return (n > 0) && (n % C1 == 0);
  endfunction

  function automatic logic exp_hour(input int n);
    return (n > 0) && (n % HP == 0) && (n / HP <= NH);
  endfunction

  function automatic int exp_wh(input int n);
    int k;
    k = hours_done(n);
    return (k > NH - 1) ? NH - 1 : k;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_on) begin
      check("m_sec",  {31'd0, expired_one_second}, {31'd0, exp_sec(n_m)});
      check("m_hour", {31'd0, expired_one_hour},   {31'd0, exp_hour(n_m)});
      check("m_wh",   {28'd0, work_hour},          exp_wh(n_m));
      check("m_day",  {31'd0, work_day_expired},   {31'd0, (hours_done(n_m) >= NH)});
      check("m_rd",   {16'd0, rd_data},            {16'd0, rd_m});
    end
  end

  task automatic rand_ram();
    wr_en   = 1'($urandom_range(0, 1));
    wr_addr = 3'($urandom_range(0, 7));
    wr_data = 16'($urandom);
    rd_addr = 3'($urandom_range(0, 7));
  endtask

  initial begin
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    check("rst_wh",  {28'd0, work_hour}, 32'd0);
    check("rst_day", {31'd0, work_day_expired}, 32'd0);
    check("rst_rd",  {16'd0, rd_data}, 32'd0);
    reset = 1'b1;

    // First day: directed RAM accesses early, then random RAM traffic.
    for (int c = 1; c <= 240; c++) begin
      @(negedge clk);
      if (c == 2)   check("rw_same_old", {16'd0, rd_data}, 32'h0000);
      if (c == 3)   check("rw_same_new", {16'd0, rd_data}, 32'hABCD);
      if (c == 4)   check("sec_c4",  {31'd0, expired_one_second}, 32'd0);
      if (c == 5) begin
        check("sec_c5",  {31'd0, expired_one_second}, 32'd1);
        check("rd_m3",   {16'd0, rd_data}, 32'h0005);
      end
      if (c == 6) begin
        check("sec_c6",  {31'd0, expired_one_second}, 32'd0);
        check("rd_noupd", {16'd0, rd_data}, 32'h0005);
      end
      if (c == 25) begin
        check("hr1_pulse", {31'd0, expired_one_hour}, 32'd1);
        check("hr1_sec",   {31'd0, expired_one_second}, 32'd1);
        check("hr1_wh",    {28'd0, work_hour}, 32'd0);
      end
      if (c == 26) begin
        check("hr1_next_wh",  {28'd0, work_hour}, 32'd1);
        check("hr1_next_eh",  {31'd0, expired_one_hour}, 32'd0);
      end
      if (c == 200) begin
        check("hr8_pulse", {31'd0, expired_one_hour}, 32'd1);
        check("hr8_wh",    {28'd0, work_hour}, 32'd7);
        check("hr8_day",   {31'd0, work_day_expired}, 32'd0);
      end
      if (c == 201) begin
        check("day_set",  {31'd0, work_day_expired}, 32'd1);
        check("day_wh",   {28'd0, work_hour}, 32'd7);
      end
      if (c == 225) begin
        check("post_sec", {31'd0, expired_one_second}, 32'd1);
        check("post_eh",  {31'd0, expired_one_hour}, 32'd0);
      end
      case (c)
        1: begin wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'hABCD; rd_addr = 3'd2; end
        2: begin wr_en = 1'b0; rd_addr = 3'd2; end
        3: begin wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'h0005; rd_addr = 3'd0; end
        4: begin wr_en = 1'b0; wr_data = 16'h1234; rd_addr = 3'd3; end
        5: begin wr_en = 1'b0; wr_addr = 3'd3; wr_data = 16'hFFFF; rd_addr = 3'd3; end
        default: rand_ram();
      endcase
    end

    // New-day request after expiry.
    wr_en = 1'b0;
    work_day_increment = 1'b1;
    @(negedge clk);
    work_day_increment = 1'b0;
    check("nd_day", {31'd0, work_day_expired}, 32'd0);
    check("nd_wh",  {28'd0, work_hour}, 32'd0);
    check("nd_sec", {31'd0, expired_one_second}, 32'd0);
    for (int j = 1; j <= 5; j++) begin
      @(negedge clk);
      check("nd_first_sec", {31'd0, expired_one_second}, {31'd0, (j == 5)});
    end

    // Random traffic with occasional new-day requests.
    for (int c = 0; c < 700; c++) begin
      rand_ram();
      work_day_increment = ($urandom_range(0, 149) == 0);
      @(negedge clk);
    end
    work_day_increment = 1'b0;

    // Load RAM, then asynchronous reset in the middle of an hour.
    for (int c = 0; c < 37; c++) begin
      wr_en   = 1'b1;
      wr_addr = 3'($urandom_range(0, 7));
      wr_data = 16'($urandom_range(1, 65535));
      rd_addr = wr_addr;
      @(negedge clk);
    end
    wr_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    check("arst_wh",  {28'd0, work_hour}, 32'd0);
    check("arst_sec", {31'd0, expired_one_second}, 32'd0);
    check("arst_eh",  {31'd0, expired_one_hour}, 32'd0);
    check("arst_day", {31'd0, work_day_expired}, 32'd0);
    check("arst_rd",  {16'd0, rd_data}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 3'(i);
      @(negedge clk);
      check("ram_cleared", {16'd0, rd_data}, 32'd0);
    end

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/hour_timer_log.md
Name: hour_timer_log

Overview:
- Work-day timebase plus per-hour log storage for the parking system.
- Divides the system clock into one-second ticks and work-hour ticks, and tracks the current work hour (0..7) and work-day completion.
- Contains an 8x16 simple dual-port RAM (one write port, one read port) that the car tracker fills once per hour and reads back after the day ends.

Parameters:
- CNT_1S, 50_000_000: clock cycles per second; must be >= 2.
- CNT_HOUR, 3600: seconds per work hour; must be >= 1.
- NUM_HOURS, 8: work hours per day; must be 1..8 because it is limited by RAM depth.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- work_day_increment  input  1  synchronous start-new-day request, level-sampled.
- work_hour  output  4  current work hour, 0..NUM_HOURS-1.
- expired_one_second  output  1  one-cycle pulse per elapsed second.
- expired_one_hour  output  1  one-cycle pulse per elapsed work hour.
- work_day_expired  output  1  high level once all NUM_HOURS hours have elapsed.
- wr_addr  input  3  RAM write address.
- wr_data  input  16  RAM write data.
- wr_en  input  1  RAM write enable.
- rd_addr  input  3  RAM read address.
- rd_data  output  16  RAM read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - cycle counter, second counter, work_hour, expired_one_second, expired_one_hour, work_day_expired and rd_data all clear to 0.
  - All 8 RAM words clear to 0.
  - Outputs remain 0 while reset is held.
- Cycle counter: counts 0..CNT_1S-1 and wraps to 0.
  - expired_one_second is registered and goes high for exactly one cycle on the clock edge where the counter wraps.
  - First pulse appears CNT_1S cycles after reset release; period is CNT_1S cycles.
  - Second ticks keep running after work_day_expired is set.
- Second counter: counts second ticks 0..CNT_HOUR-1.
  - On the tick that wraps it, expired_one_hour pulses high for one cycle, coincident with that expired_one_second pulse.
  - Hour period is CNT_1S*CNT_HOUR cycles.
- work_hour holds its value through the cycle in which expired_one_hour is high, so consumers sampling on that pulse see the hour just completed.
  - On the following edge it increments by 1.
  - When hour NUM_HOURS-1 completes, work_hour holds at NUM_HOURS-1 instead of incrementing, and work_day_expired sets to 1 (visible the cycle after the final expired_one_hour pulse).
- After the day expires:
  - work_day_expired stays 1.
  - No further expired_one_hour pulses are generated.
  - The second counter is frozen at 0.
- work_day_increment=1 at a clock edge:
  - Clears work_hour, the second counter, the cycle counter and work_day_expired.
  - Suppresses any pulse on that edge.
  - Counting restarts on the next edge.
  - Has priority over simultaneous tick or expiry events.
  - Does not clear RAM contents.
- RAM write: synchronous. When wr_en=1, mem[wr_addr] <= wr_data at the rising edge. When wr_en=0 there is no change.
- RAM read: synchronous, 1-cycle latency; rd_data <= mem[rd_addr] every edge.
  - Read and write to the same address on the same edge returns the old data; the new data is visible one cycle later.
- Address width is 3 bits, so all addresses are valid and there is no out-of-range case.

Test Plan:
- CNT_1S=5, CNT_HOUR=5, release reset -> expired_one_second pulses 1 cycle every 5 clocks; expired_one_hour pulses every 25 clocks, coincident with a second pulse; work_hour reads 0 during the first hour pulse and 1 on the next cycle.
- Same parameters, run 200+ cycles -> work_hour steps 0..7 and holds at 7; work_day_expired rises 1 cycle after the 8th hour pulse and stays high; second pulses continue; no further hour pulses.
- Assert work_day_increment for 1 cycle after the day expires -> work_day_expired=0, work_hour=0; the first new second pulse appears 5 cycles later.
- Write mem[3]=16'h0005 with wr_en=1, then rd_addr=3 -> rd_data=16'h0005 one cycle after the address is applied; with wr_en=0, changing wr_data causes no update.
- Same-address read/write on one edge (mem[2] old=0, write 16'hABCD) -> rd_data=0 that cycle and 16'hABCD the next.
- Pull reset low mid-hour with RAM loaded -> all outputs 0 immediately without waiting for a clock; RAM reads 0 at every address after reset release.
